// File: rtl/updown_counter_mod_pkg.sv
// Shared definitions for the modulo-N up/down counter: mode encoding and a
// width helper used by the prescaler.
package updown_counter_mod_pkg;

  localparam logic MODE_DOWN = 1'b0;
  localparam logic MODE_UP   = 1'b1;

  // Width of a counter holding 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/updown_counter_mod_tick_gen.sv
// Tick prescaler: emits a one-cycle step every TICK_DIV enabled cycles. The
// phase freezes while enable is low and restarts from zero on clear_div.
module tick_gen
  import updown_counter_mod_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear_div,
  output logic step
);

  generate
    if (TICK_DIV <= 1) begin : g_bypass
      logic w_unused;
      assign w_unused = ^{clk, rst, clear_div};
      assign step     = enable;
    end else begin : g_div
      localparam int unsigned DW = cnt_width(TICK_DIV);
      localparam logic [DW-1:0] LP_LAST = DW'(TICK_DIV - 1);

      logic [DW-1:0] r_div_cnt;
      logic          w_last;

      assign w_last = (r_div_cnt == LP_LAST);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_div_cnt <= '0;
        end else if (clear_div) begin
          r_div_cnt <= '0;
        end else if (enable) begin
          r_div_cnt <= w_last ? '0 : r_div_cnt + DW'(1);
        end
      end

      assign step = enable && w_last;
    end
  endgenerate

endmodule

// File: rtl/updown_counter_mod.sv
// Modulo-MAX_COUNT up/down counter with prescaled stepping, synchronous
// clear/load, wrap or saturate at the boundaries, and registered tick/tc pulses.
module updown_counter_mod
  import updown_counter_mod_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 10000,
  parameter int unsigned TICK_DIV  = 100000,
  parameter bit          SATURATE  = 1'b0,
  localparam int unsigned W        = $clog2(MAX_COUNT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         clear,
  input  logic         mode,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count_reg,
  output logic         tick_o,
  output logic         tc
);

  localparam logic [W-1:0] LP_TOP = W'(MAX_COUNT - 1);

  logic [W-1:0] r_count;
  logic         r_tick;
  logic         r_tc;

  logic         w_step;
  logic         w_clear_div;
  logic [W-1:0] w_next;
  logic         w_boundary;
  logic [W-1:0] w_load_clamped;

  assign w_clear_div = clear | load;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .clear_div (w_clear_div),
    .step      (w_step)
  );

  assign w_load_clamped = (load_val > LP_TOP) ? LP_TOP : load_val;

  // Boundary is MAX_COUNT-1, not the all-ones value of the register.
  always_comb begin
    w_next     = r_count;
    w_boundary = 1'b0;
    if (mode == MODE_UP) begin
      if (r_count >= LP_TOP) begin
        w_boundary = 1'b1;
        w_next     = SATURATE ? r_count : '0;
      end else begin
        w_next = r_count + W'(1);
      end
    end else begin
      if (r_count == '0) begin
        w_boundary = 1'b1;
        w_next     = SATURATE ? r_count : LP_TOP;
      end else begin
        w_next = r_count - W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_tc   <= 1'b0;
      if (clear) begin
        r_count <= '0;
      end else if (load) begin
        r_count <= w_load_clamped;
      end else if (w_step) begin
        r_count <= w_next;
        r_tick  <= 1'b1;
        r_tc    <= w_boundary;
      end
    end
  end

  assign count_reg = r_count;
  assign tick_o    = r_tick;
  assign tc        = r_tc;

endmodule
